// File: rtl/vtg_pkg.sv
// vtg_pkg: shared types, 1080p60 defaults and helper functions for the VESA timing generator.
package vtg_pkg;

  localparam int TW = 16;

  localparam int unsigned VTG_DEF_H_ACT  = 32'd1920;
  localparam int unsigned VTG_DEF_H_FP   = 32'd88;
  localparam int unsigned VTG_DEF_H_SYNC = 32'd44;
  localparam int unsigned VTG_DEF_H_BP   = 32'd148;
  localparam int unsigned VTG_DEF_V_ACT  = 32'd1080;
  localparam int unsigned VTG_DEF_V_FP   = 32'd4;
  localparam int unsigned VTG_DEF_V_SYNC = 32'd5;
  localparam int unsigned VTG_DEF_V_BP   = 32'd36;

  typedef struct packed {
    logic [TW-1:0] act;
    logic [TW-1:0] fp;
    logic [TW-1:0] sync;
    logic [TW-1:0] bp;
    logic          pol;
  } timing_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vtg_state_e;

  function automatic logic [TW+1:0] timing_total(input timing_t t);
    return {2'b00, t.act} + {2'b00, t.fp} + {2'b00, t.sync} + {2'b00, t.bp};
  endfunction

  // Non-zero active and sync widths, and a total that fits a w-bit counter
  function automatic logic timing_valid(input timing_t t, input int unsigned w);
    logic [TW+1:0] tot;
    tot = timing_total(t);
    return (t.act != 16'd0) && (t.sync != 16'd0) && ((tot >> w) == 18'd0);
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vtg_axis.sv
// vtg_axis: one timing axis (counter plus sync/active decode), used for both H and V.
module vtg_axis
  import vtg_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         adv,
  input  logic [W-1:0] act,
  input  logic [W-1:0] fp,
  input  logic [W-1:0] sync,
  input  logic [W:0]   tot,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         sync_on,
  output logic         active
);

  logic [W-1:0] cnt_r;
  logic [W:0]   cnt_ext_s;
  logic [W:0]   sync_beg_s;
  logic [W:0]   sync_end_s;

  // Position decode against the registered count
  always_comb begin
    cnt_ext_s  = {1'b0, cnt_r};
    sync_beg_s = {1'b0, act} + {1'b0, fp};
    sync_end_s = sync_beg_s + {1'b0, sync};
    last       = (cnt_ext_s == (tot - {{W{1'b0}}, 1'b1}));
    sync_on    = (cnt_ext_s >= sync_beg_s) && (cnt_ext_s < sync_end_s);
    active     = (cnt_r < act);
  end

  // Position counter: cleared while not running, wraps on the last position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (!run) begin
      cnt_r <= {W{1'b0}};
    end else if (adv) begin
      if (last) begin
        cnt_r <= {W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/vesa_timing_gen_cfg.sv
// vesa_timing_gen_cfg: runtime-programmable VESA timing generator; config applied at frame end.
// Define VTG_PATTERN_EN to add the pat_rgb colour-bar output. Field widths HW/VW must stay below 16.
module vesa_timing_gen_cfg
  import vtg_pkg::*;
#(
  parameter int          HW         = 12,
  parameter int          VW         = 11,
  parameter int unsigned DEF_H_ACT  = VTG_DEF_H_ACT,
  parameter int unsigned DEF_H_FP   = VTG_DEF_H_FP,
  parameter int unsigned DEF_H_SYNC = VTG_DEF_H_SYNC,
  parameter int unsigned DEF_H_BP   = VTG_DEF_H_BP,
  parameter int unsigned DEF_V_ACT  = VTG_DEF_V_ACT,
  parameter int unsigned DEF_V_FP   = VTG_DEF_V_FP,
  parameter int unsigned DEF_V_SYNC = VTG_DEF_V_SYNC,
  parameter int unsigned DEF_V_BP   = VTG_DEF_V_BP,
  parameter logic        DEF_HS_POL = 1'b1,
  parameter logic        DEF_VS_POL = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [HW-1:0] cfg_h_act,
  input  logic [HW-1:0] cfg_h_fp,
  input  logic [HW-1:0] cfg_h_sync,
  input  logic [HW-1:0] cfg_h_bp,
  input  logic [VW-1:0] cfg_v_act,
  input  logic [VW-1:0] cfg_v_fp,
  input  logic [VW-1:0] cfg_v_sync,
  input  logic [VW-1:0] cfg_v_bp,
  input  logic          cfg_hs_pol,
  input  logic          cfg_vs_pol,
  input  logic          cfg_load,
  output logic          cfg_pending,
  output logic          cfg_err,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frame_start,
  output logic          line_start,
  output logic [HW-1:0] h_count,
  output logic [VW-1:0] v_count,
  output logic [HW-1:0] pix_x,
  output logic [VW-1:0] pix_y
`ifdef VTG_PATTERN_EN
  ,
  output logic [23:0]   pat_rgb
`endif
);

  localparam timing_t DEF_H_TIM = '{act: TW'(DEF_H_ACT), fp: TW'(DEF_H_FP),
                                    sync: TW'(DEF_H_SYNC), bp: TW'(DEF_H_BP), pol: DEF_HS_POL};
  localparam timing_t DEF_V_TIM = '{act: TW'(DEF_V_ACT), fp: TW'(DEF_V_FP),
                                    sync: TW'(DEF_V_SYNC), bp: TW'(DEF_V_BP), pol: DEF_VS_POL};

  vtg_state_e    state_r, state_nxt_s;
  timing_t       h_req_s, v_req_s, h_shd_r, v_shd_r;
  logic          req_ok_s, pend_r, err_r;
  logic [HW-1:0] h_act_r, h_fp_r, h_sync_r;
  logic [VW-1:0] v_act_r, v_fp_r, v_sync_r;
  logic [HW:0]   h_tot_r;
  logic [VW:0]   v_tot_r;
  logic          h_pol_r, v_pol_r;
  logic          run_s, apply_s, h_wrap_s, de_s;
  logic [HW-1:0] h_cnt_s;
  logic [VW-1:0] v_cnt_s;
  logic          h_last_s, v_last_s, h_sync_on_s, v_sync_on_s, h_active_s, v_active_s;
  logic          hsync_r, vsync_r, de_r, frame_start_r, line_start_r;
  logic [HW-1:0] h_count_r, pix_x_r;
  logic [VW-1:0] v_count_r, pix_y_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; disabling aborts the frame immediately
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = enable ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nxt_s = enable ? ST_RUN : ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Request check and apply decision
  always_comb begin
    h_req_s  = '{act: TW'(cfg_h_act), fp: TW'(cfg_h_fp), sync: TW'(cfg_h_sync),
                 bp: TW'(cfg_h_bp), pol: cfg_hs_pol};
    v_req_s  = '{act: TW'(cfg_v_act), fp: TW'(cfg_v_fp), sync: TW'(cfg_v_sync),
                 bp: TW'(cfg_v_bp), pol: cfg_vs_pol};
    req_ok_s = timing_valid(h_req_s, HW) && timing_valid(v_req_s, VW);
    run_s    = (state_r == ST_RUN) && enable;
    h_wrap_s = run_s && h_last_s;
    apply_s  = pend_r && ((state_r == ST_IDLE) || (h_wrap_s && v_last_s));
    de_s     = h_active_s && v_active_s;
  end

  // Shadow capture and active-timing apply; the apply reads the shadow before this edge's load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_shd_r  <= DEF_H_TIM;
      v_shd_r  <= DEF_V_TIM;
      pend_r   <= 1'b0;
      err_r    <= 1'b0;
      h_act_r  <= HW'(DEF_H_ACT);
      h_fp_r   <= HW'(DEF_H_FP);
      h_sync_r <= HW'(DEF_H_SYNC);
      h_tot_r  <= (HW+1)'(DEF_H_ACT + DEF_H_FP + DEF_H_SYNC + DEF_H_BP);
      h_pol_r  <= DEF_HS_POL;
      v_act_r  <= VW'(DEF_V_ACT);
      v_fp_r   <= VW'(DEF_V_FP);
      v_sync_r <= VW'(DEF_V_SYNC);
      v_tot_r  <= (VW+1)'(DEF_V_ACT + DEF_V_FP + DEF_V_SYNC + DEF_V_BP);
      v_pol_r  <= DEF_VS_POL;
    end else begin
      err_r <= cfg_load && !req_ok_s;
      if (cfg_load && req_ok_s) begin
        h_shd_r <= h_req_s;
        v_shd_r <= v_req_s;
        pend_r  <= 1'b1;
      end else if (apply_s) begin
        pend_r  <= 1'b0;
      end
      if (apply_s) begin
        h_act_r  <= h_shd_r.act[HW-1:0];
        h_fp_r   <= h_shd_r.fp[HW-1:0];
        h_sync_r <= h_shd_r.sync[HW-1:0];
        h_tot_r  <= (HW+1)'(timing_total(h_shd_r));
        h_pol_r  <= h_shd_r.pol;
        v_act_r  <= v_shd_r.act[VW-1:0];
        v_fp_r   <= v_shd_r.fp[VW-1:0];
        v_sync_r <= v_shd_r.sync[VW-1:0];
        v_tot_r  <= (VW+1)'(timing_total(v_shd_r));
        v_pol_r  <= v_shd_r.pol;
      end
    end
  end

  vtg_axis #(.W(HW)) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run_s),
    .adv     (1'b1),
    .act     (h_act_r),
    .fp      (h_fp_r),
    .sync    (h_sync_r),
    .tot     (h_tot_r),
    .cnt     (h_cnt_s),
    .last    (h_last_s),
    .sync_on (h_sync_on_s),
    .active  (h_active_s)
  );

  vtg_axis #(.W(VW)) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run_s),
    .adv     (h_wrap_s),
    .act     (v_act_r),
    .fp      (v_fp_r),
    .sync    (v_sync_r),
    .tot     (v_tot_r),
    .cnt     (v_cnt_s),
    .last    (v_last_s),
    .sync_on (v_sync_on_s),
    .active  (v_active_s)
  );

  // Output stage: every output trails the counters by exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_r       <= ~DEF_HS_POL;
      vsync_r       <= ~DEF_VS_POL;
      de_r          <= 1'b0;
      frame_start_r <= 1'b0;
      line_start_r  <= 1'b0;
      h_count_r     <= {HW{1'b0}};
      v_count_r     <= {VW{1'b0}};
      pix_x_r       <= {HW{1'b0}};
      pix_y_r       <= {VW{1'b0}};
    end else if (run_s) begin
      hsync_r       <= h_sync_on_s ? h_pol_r : ~h_pol_r;
      vsync_r       <= v_sync_on_s ? v_pol_r : ~v_pol_r;
      de_r          <= de_s;
      frame_start_r <= (h_cnt_s == {HW{1'b0}}) && (v_cnt_s == {VW{1'b0}});
      line_start_r  <= (h_cnt_s == {HW{1'b0}});
      h_count_r     <= h_cnt_s;
      v_count_r     <= v_cnt_s;
      pix_x_r       <= de_s ? h_cnt_s : {HW{1'b0}};
      pix_y_r       <= de_s ? v_cnt_s : {VW{1'b0}};
    end else begin
      hsync_r       <= ~h_pol_r;
      vsync_r       <= ~v_pol_r;
      de_r          <= 1'b0;
      frame_start_r <= 1'b0;
      line_start_r  <= 1'b0;
      h_count_r     <= {HW{1'b0}};
      v_count_r     <= {VW{1'b0}};
      pix_x_r       <= {HW{1'b0}};
      pix_y_r       <= {VW{1'b0}};
    end
  end

  assign cfg_pending = pend_r;
  assign cfg_err     = err_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign de          = de_r;
  assign frame_start = frame_start_r;
  assign line_start  = line_start_r;
  assign h_count     = h_count_r;
  assign v_count     = v_count_r;
  assign pix_x       = pix_x_r;
  assign pix_y       = pix_y_r;

`ifdef VTG_PATTERN_EN
  logic [2:0]    bar_idx_r;
  logic [HW-1:0] bar_rem_r, bar_w_s, bar_rld_s;
  logic [23:0]   pat_rgb_r;

  // Bar width comes from the timing that will be active for the next pixel
  always_comb begin
    bar_w_s   = apply_s ? (h_shd_r.act[HW-1:0] >> 3) : (h_act_r >> 3);
    bar_rld_s = (bar_w_s == {HW{1'b0}}) ? {HW{1'b0}} : (bar_w_s - {{(HW-1){1'b0}}, 1'b1});
  end

  // Bar tracker mirrors h_cnt; the final bar absorbs leftover pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_idx_r <= 3'd0;
      bar_rem_r <= {HW{1'b0}};
      pat_rgb_r <= 24'h000000;
    end else begin
      pat_rgb_r <= (run_s && de_s) ? bar_colour(bar_idx_r) : 24'h000000;
      if (!run_s || h_wrap_s) begin
        bar_idx_r <= 3'd0;
        bar_rem_r <= bar_rld_s;
      end else if (bar_rem_r != {HW{1'b0}}) begin
        bar_rem_r <= bar_rem_r - {{(HW-1){1'b0}}, 1'b1};
      end else if (bar_idx_r != 3'd7) begin
        bar_idx_r <= bar_idx_r + 3'd1;
        bar_rem_r <= bar_rld_s;
      end
    end
  end

  assign pat_rgb = pat_rgb_r;
`endif

endmodule

// File: tb/tb_vesa_timing_gen_cfg.sv
// tb_vesa_timing_gen_cfg: directed self-checking bench for the programmable VESA timing generator.
module tb_vesa_timing_gen_cfg;

  localparam int HW = 12;
  localparam int VW = 11;

  logic          clk = 1'b0;
  logic          rst_n, enable, cfg_load, cfg_hs_pol, cfg_vs_pol;
  logic [HW-1:0] cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [VW-1:0] cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic          cfg_pending, cfg_err, hsync, vsync, de, frame_start, line_start;
  logic [HW-1:0] h_count, pix_x;
  logic [VW-1:0] v_count, pix_y;
`ifdef VTG_PATTERN_EN
  logic [23:0]   pat_rgb;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  vesa_timing_gen_cfg dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol), .cfg_load(cfg_load),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start), .line_start(line_start), .h_count(h_count), .v_count(v_count),
    .pix_x(pix_x), .pix_y(pix_y)
`ifdef VTG_PATTERN_EN
    , .pat_rgb(pat_rgb)
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int ha, input int hf, input int hs, input int hb,
                         input int va, input int vf, input int vs, input int vb,
                         input logic hp, input logic vp);
    cfg_h_act = HW'(ha); cfg_h_fp = HW'(hf); cfg_h_sync = HW'(hs); cfg_h_bp = HW'(hb);
    cfg_v_act = VW'(va); cfg_v_fp = VW'(vf); cfg_v_sync = VW'(vs); cfg_v_bp = VW'(vb);
    cfg_hs_pol = hp; cfg_vs_pol = vp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; cfg_load = 1'b0;
    set_cfg(1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1, 1'b1);
    repeat (3) step();
    vec_cnt++; if (hsync !== 1'b0) begin err_cnt++; $display("FAIL reset_hsync got %b exp 0", hsync); end
    vec_cnt++; if (vsync !== 1'b0) begin err_cnt++; $display("FAIL reset_vsync got %b exp 0", vsync); end
    vec_cnt++; if ({de, frame_start, line_start, cfg_pending, cfg_err} !== 5'b0) begin
      err_cnt++; $display("FAIL reset_flags got %b exp 00000", {de, frame_start, line_start, cfg_pending, cfg_err});
    end
    vec_cnt++; if ({h_count, v_count, pix_x, pix_y} !== 46'd0) begin
      err_cnt++; $display("FAIL reset_counts got h=%0d v=%0d x=%0d y=%0d exp 0", h_count, v_count, pix_x, pix_y);
    end
    rst_n = 1'b1;
    repeat (2) step();
    vec_cnt++; if ({de, frame_start, hsync} !== 3'b0) begin
      err_cnt++; $display("FAIL idle_after_reset got %b exp 000", {de, frame_start, hsync});
    end
  endtask

  task automatic test_default_timing();
    int hs_hi = 0, de_hi = 0, ls = 0, vs_hi = 0, fs = 0, pix_bad = 0, first_hs = -1;
    enable = 1'b1;
    step();
    vec_cnt++; if (frame_start !== 1'b0) begin err_cnt++; $display("FAIL start_latency got fs=%b exp 0", frame_start); end
    step();
    vec_cnt++; if ({frame_start, de, h_count, v_count, pix_x, pix_y} !== {1'b1, 1'b1, 46'd0}) begin
      err_cnt++; $display("FAIL first_pixel got fs=%b de=%b h=%0d v=%0d x=%0d y=%0d exp 1 1 0 0 0 0",
                          frame_start, de, h_count, v_count, pix_x, pix_y);
    end
    for (int i = 0; i < 4400; i++) begin
      if (hsync === 1'b1) begin hs_hi++; if (first_hs < 0) first_hs = int'(h_count); end
      if (de === 1'b1) de_hi++;
      if (line_start === 1'b1) ls++;
      if (vsync === 1'b1) vs_hi++;
      if (frame_start === 1'b1) fs++;
      if (de === 1'b1 ? (pix_x !== h_count || pix_y !== v_count) : (pix_x !== '0 || pix_y !== '0)) pix_bad++;
      step();
    end
    vec_cnt++; if (hs_hi != 88) begin err_cnt++; $display("FAIL def_hsync_width got %0d exp 88", hs_hi); end
    vec_cnt++; if (first_hs != 2008) begin err_cnt++; $display("FAIL def_hsync_pos got %0d exp 2008", first_hs); end
    vec_cnt++; if (de_hi != 3840) begin err_cnt++; $display("FAIL def_de_count got %0d exp 3840", de_hi); end
    vec_cnt++; if (ls != 2) begin err_cnt++; $display("FAIL def_line_start got %0d exp 2", ls); end
    vec_cnt++; if (vs_hi != 0) begin err_cnt++; $display("FAIL def_vsync_idle got %0d exp 0", vs_hi); end
    vec_cnt++; if (fs != 1) begin err_cnt++; $display("FAIL def_frame_start got %0d exp 1", fs); end
    vec_cnt++; if (pix_bad != 0) begin err_cnt++; $display("FAIL def_pix_xy got %0d bad exp 0", pix_bad); end
  endtask

  task automatic test_cfg_reject();
    int tbl [4][8] = '{'{0, 2, 4, 2, 8, 1, 2, 1}, '{4000, 100, 4, 2, 8, 1, 2, 1},
                       '{16, 2, 4, 2, 8, 1, 0, 1}, '{16, 2, 4, 2, 2040, 4, 4, 4}};
    for (int k = 0; k < 4; k++) begin
      set_cfg(tbl[k][0], tbl[k][1], tbl[k][2], tbl[k][3], tbl[k][4], tbl[k][5], tbl[k][6], tbl[k][7], 1'b0, 1'b0);
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      vec_cnt++; if ({cfg_err, cfg_pending} !== 2'b10) begin
        err_cnt++; $display("FAIL reject_%0d got err=%b pend=%b exp 1 0", k, cfg_err, cfg_pending);
      end
      step();
      vec_cnt++; if (cfg_err !== 1'b0) begin err_cnt++; $display("FAIL reject_pulse_%0d got %b exp 0", k, cfg_err); end
    end
  endtask

  task automatic test_pending_and_abort();
    int n = 0;
    set_cfg(16, 2, 4, 2, 8, 1, 2, 1, 1'b0, 1'b0);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    vec_cnt++; if ({cfg_pending, cfg_err} !== 2'b10) begin
      err_cnt++; $display("FAIL load_pending got pend=%b err=%b exp 1 0", cfg_pending, cfg_err);
    end
    do begin step(); n++; end while (line_start !== 1'b1 && n < 5000);
    vec_cnt++; if (n != 2191 || v_count !== 11'd3) begin
      err_cnt++; $display("FAIL old_timing_kept got %0d cycles v=%0d exp 2191 v=3", n, v_count);
    end
    repeat (10) step();
    vec_cnt++; if (h_count !== 12'd10 || v_count !== 11'd3 || de !== 1'b1) begin
      err_cnt++; $display("FAIL abort_point got h=%0d v=%0d de=%b exp 10 3 1", h_count, v_count, de);
    end
    enable = 1'b0;
    step();
    vec_cnt++; if ({de, hsync, vsync, frame_start, cfg_pending} !== 5'b00001 || h_count !== '0 || v_count !== '0) begin
      err_cnt++; $display("FAIL abort_idle got de=%b hs=%b vs=%b fs=%b pend=%b h=%0d v=%0d exp 0 0 0 0 1 0 0",
                          de, hsync, vsync, frame_start, cfg_pending, h_count, v_count);
    end
    repeat (3) step();
    vec_cnt++; if ({cfg_pending, hsync, vsync} !== 3'b011) begin
      err_cnt++; $display("FAIL idle_apply got pend=%b hs=%b vs=%b exp 0 1 1", cfg_pending, hsync, vsync);
    end
    enable = 1'b1;
    step();
    vec_cnt++; if (frame_start !== 1'b0) begin err_cnt++; $display("FAIL rerun_latency got fs=%b exp 0", frame_start); end
    step();
    vec_cnt++; if ({frame_start, de} !== 2'b11 || pix_x !== '0 || pix_y !== '0) begin
      err_cnt++; $display("FAIL rerun_first got fs=%b de=%b x=%0d y=%0d exp 1 1 0 0", frame_start, de, pix_x, pix_y);
    end
  endtask

  task automatic test_small_frame();
    int hs_lo = 0, hs_bad = 0, vs_lo = 0, ls = 0, de_hi = 0, fs = 0, pat_bad = 0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    for (int i = 0; i < 288; i++) begin
      if (hsync === 1'b0) begin hs_lo++; if (h_count < 12'd18 || h_count > 12'd21) hs_bad++; end
      if (vsync === 1'b0) vs_lo++;
      if (line_start === 1'b1) ls++;
      if (de === 1'b1) de_hi++;
      if (frame_start === 1'b1) fs++;
`ifdef VTG_PATTERN_EN
      if (pat_rgb !== (de === 1'b1 ? bars[(i % 24) / 2] : 24'h000000)) pat_bad++;
`else
      if (bars[0] !== 24'hFFFFFF) pat_bad++;
`endif
      step();
    end
    vec_cnt++; if (hs_lo != 48 || hs_bad != 0) begin
      err_cnt++; $display("FAIL small_hsync got low=%0d misplaced=%0d exp 48 0", hs_lo, hs_bad);
    end
    vec_cnt++; if (vs_lo != 48) begin err_cnt++; $display("FAIL small_vsync got %0d exp 48", vs_lo); end
    vec_cnt++; if (ls != 12 || fs != 1) begin err_cnt++; $display("FAIL small_lines got ls=%0d fs=%0d exp 12 1", ls, fs); end
    vec_cnt++; if (de_hi != 128) begin err_cnt++; $display("FAIL small_de got %0d exp 128", de_hi); end
    vec_cnt++; if (pat_bad != 0) begin err_cnt++; $display("FAIL pattern got %0d bad exp 0", pat_bad); end
    vec_cnt++; if (frame_start !== 1'b1) begin err_cnt++; $display("FAIL small_wrap got fs=%b exp 1", frame_start); end
  endtask

  task automatic test_frame_end_apply();
    int n = 0, hs_hi = 0, de_hi = 0, ls = 0, vs_hi = 0;
    repeat (50) step();
    set_cfg(8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    vec_cnt++; if (cfg_pending !== 1'b1) begin err_cnt++; $display("FAIL mid_load_pend got %b exp 1", cfg_pending); end
    do begin step(); n++; end while (frame_start !== 1'b1 && n < 1000);
    vec_cnt++; if (n != 237) begin err_cnt++; $display("FAIL apply_at_frame_end got %0d cycles exp 237", n); end
    vec_cnt++; if (cfg_pending !== 1'b0) begin err_cnt++; $display("FAIL applied_pend got %b exp 0", cfg_pending); end
    for (int i = 0; i < 84; i++) begin
      if (hsync === 1'b1) hs_hi++;
      if (de === 1'b1) de_hi++;
      if (line_start === 1'b1) ls++;
      if (vsync === 1'b1) vs_hi++;
      step();
    end
    vec_cnt++; if (hs_hi != 14 || vs_hi != 12) begin
      err_cnt++; $display("FAIL new_pol_sync got hs=%0d vs=%0d exp 14 12", hs_hi, vs_hi);
    end
    vec_cnt++; if (de_hi != 32 || ls != 7) begin err_cnt++; $display("FAIL new_frame got de=%0d ls=%0d exp 32 7", de_hi, ls); end
    vec_cnt++; if (frame_start !== 1'b1) begin err_cnt++; $display("FAIL new_wrap got fs=%b exp 1", frame_start); end
  endtask

  task automatic test_coincident_load();
    int n = 0, hs_lo = 0;
    repeat (82) step();
    vec_cnt++; if (h_count !== 12'd10 || v_count !== 11'd6) begin
      err_cnt++; $display("FAIL coinc_point got h=%0d v=%0d exp 10 6", h_count, v_count);
    end
    set_cfg(12, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    vec_cnt++; if (cfg_pending !== 1'b1) begin err_cnt++; $display("FAIL coinc_pend got %b exp 1", cfg_pending); end
    step();
    vec_cnt++; if ({frame_start, cfg_pending} !== 2'b11) begin
      err_cnt++; $display("FAIL coinc_held got fs=%b pend=%b exp 1 1", frame_start, cfg_pending);
    end
    do begin step(); n++; end while (frame_start !== 1'b1 && n < 1000);
    vec_cnt++; if (n != 84) begin err_cnt++; $display("FAIL coinc_old_frame got %0d cycles exp 84", n); end
    vec_cnt++; if (cfg_pending !== 1'b0) begin err_cnt++; $display("FAIL coinc_applied got %b exp 0", cfg_pending); end
    n = 0;
    do begin if (hsync === 1'b0) hs_lo++; step(); n++; end while (frame_start !== 1'b1 && n < 1000);
    vec_cnt++; if (n != 96 || hs_lo != 12) begin
      err_cnt++; $display("FAIL coinc_new_frame got %0d cycles hs_lo=%0d exp 96 12", n, hs_lo);
    end
  endtask

  initial begin
    test_reset();
    test_default_timing();
    test_cfg_reject();
    test_pending_and_abort();
    test_small_frame();
    test_frame_end_apply();
    test_coincident_load();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
